// File: rtl/obi_multi_port_ram.sv
// obi_multi_port_ram: multi-port OBI word RAM with fixed-latency responses and a sticky completion flag
module obi_multi_port_ram #(
    parameter int NUM_PORTS     = 2,
    parameter int MEM_SIZE_WORD = 40960,
    parameter int LATENCY       = 1,
    parameter int DONE_WORD     = 40704
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_PORTS-1:0]       req_i,
    output logic [NUM_PORTS-1:0]       gnt_o,
    input  logic [NUM_PORTS-1:0][31:0] addr_i,
    input  logic [NUM_PORTS-1:0]       we_i,
    input  logic [NUM_PORTS-1:0][3:0]  be_i,
    input  logic [NUM_PORTS-1:0][31:0] wdata_i,
    output logic [NUM_PORTS-1:0]       rvalid_o,
    output logic [NUM_PORTS-1:0][31:0] rdata_o,
    output logic [NUM_PORTS-1:0]       err_o,
    output logic                       done_o
);
    localparam int AW = MEM_SIZE_WORD > 1 ? $clog2(MEM_SIZE_WORD) : 1;
    logic [31:0] mem_array [MEM_SIZE_WORD];
    logic [NUM_PORTS-1:0]                     w_acc, w_oob;
    logic [NUM_PORTS-1:0][AW-1:0]             w_idx;
    logic [NUM_PORTS-1:0][31:0]               w_rd;
    logic [NUM_PORTS-1:0][LATENCY-1:0]        r_vld, r_err;
    logic [NUM_PORTS-1:0][LATENCY-1:0][31:0]  r_dat;
    logic                                     r_done;
    logic                                     w_unused;
    assign gnt_o    = req_i;
    assign done_o   = r_done;
    assign w_unused = ^{addr_i};
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_acc[p]    = req_i[p] & ~rst_i;
            w_oob[p]    = addr_i[p][31:2] >= 30'(MEM_SIZE_WORD);
            w_idx[p]    = addr_i[p][AW+1:2];
            w_rd[p]     = (!w_acc[p] || we_i[p]) ? 32'h0 : w_oob[p] ? 32'hDEAD_BEEF : mem_array[w_idx[p]];
            rvalid_o[p] = r_vld[p][LATENCY-1];
            rdata_o[p]  = r_dat[p][LATENCY-1];
            err_o[p]    = r_err[p][LATENCY-1];
        end
    end
    // Descending port order so the lowest-index port's byte lands last and wins.
    always_ff @(posedge clk_i) begin
        for (int p = NUM_PORTS - 1; p >= 0; p--)
            for (int b = 0; b < 4; b++)
                if (w_acc[p] && we_i[p] && !w_oob[p] && be_i[p][b])
                    mem_array[w_idx[p]][8*b +: 8] <= wdata_i[p][8*b +: 8];
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vld  <= '0;
            r_err  <= '0;
            r_dat  <= '0;
            r_done <= 1'b0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_vld[p][0] <= w_acc[p];
                r_err[p][0] <= w_acc[p] & w_oob[p];
                r_dat[p][0] <= w_rd[p];
                for (int s = 1; s < LATENCY; s++) begin
                    r_vld[p][s] <= r_vld[p][s-1];
                    r_err[p][s] <= r_err[p][s-1];
                    r_dat[p][s] <= r_dat[p][s-1];
                end
            end
            r_done <= r_done | (mem_array[AW'(DONE_WORD)] == 32'h1);
        end
    end
endmodule
